fetch_pc_ctrl: RTL and testbench
================================

Name: fetch_pc_ctrl

Overview:
- Fetch-stage next-PC generator directly upstream of the branch target buffer.
- Owns the architectural fetch PC and drives the BTB lookup PC (fetch_pc).
- Consumes the BTB's same-cycle prediction/target and the EX-stage branch resolution.
- Tracks each prediction down a 2-entry shadow pipe (DEC, EX), detects mispredicts in EX, redirects the PC, and flushes younger stages.

Parameters:
RESET_PC, 16'h0000, fetch address loaded on reset
PC_W, 16, PC/target width (word-addressed; sequential PC = pc+1)

Ports:
clk  in  1  system clock; all state on posedge
rst  in  1  asynchronous, active-low reset (rst=0 resets)
stall  in  1  hazard hold from decode; freezes PC and shadow pipe
btb_prediction  in  1  BTB predicts taken for current fetch_pc
btb_target  in  PC_W  BTB predicted target for current fetch_pc
ex_branch  in  1  EX holds a conditional jump (JUMPL/G/E/NE)
ex_taken  in  1  resolved direction of the EX branch
ex_target  in  PC_W  resolved target of the EX branch
fetch_pc  out  PC_W  PC presented to imem and BTB
fetch_valid  out  1  fetch_pc is a real fetch (0 = bubble)
pred_taken  out  1  prediction used for the instruction at fetch_pc
flush  out  1  squash IF and DEC instructions this cycle
mispredict  out  1  EX branch outcome differed from its prediction

Behaviour:
- Reset (rst=0, asynchronous): fetch_pc=RESET_PC, fetch_valid=0, pred_taken=0, flush=0, mispredict=0; shadow entries invalid; state=BOOT.
- States:
  - BOOT: exactly one cycle after rst rises; fetch_valid=0; BTB input ignored; -> RUN.
  - RUN: fetch_valid=1.
  - REDIRECT: one cycle after a mispredict; fetch_valid=1, fetch_pc=corrected PC; -> RUN (or REDIRECT again on a new mispredict).
- Shadow entry fields: {valid, pred_taken, pred_target, pc+1}.
- Shadow pipe advance (each posedge, no stall, no mispredict):
  - DEC <= {fetch_valid, pred_taken, btb_target, fetch_pc+1}.
  - EX <= DEC.
- Next PC (RUN/REDIRECT, priority high to low):
  - mispredict: pc <= ex_taken ? ex_target : EX.pc+1.
  - stall: pc holds.
  - btb_prediction=1: pc <= btb_target.
  - otherwise: pc <= fetch_pc+1.
- PC arithmetic wraps modulo 2^PC_W (16'hFFFF+1 = 16'h0000).
- pred_taken = btb_prediction when fetch_valid=1, else 0.
- Mispredict (combinational):
  - Condition: EX.valid & ex_branch & (ex_taken != EX.pred_taken | (ex_taken & EX.pred_taken & ex_target != EX.pred_target)).
  - Drives mispredict=flush=1 in the same cycle.
  - On that posedge, DEC and EX are invalidated and state -> REDIRECT.
- Simultaneous events:
  - mispredict overrides stall: the PC redirects and the shadow pipe clears even when stall=1.
  - EX.valid=0 (bubble) never raises mispredict, regardless of ex_branch.
- A non-branch in EX (ex_branch=0) with pred_taken=1 is not a mispredict. The BTB only allocates conditional jumps, so this case is not expected; it is ignored.
- Stall: fetch_pc, DEC, EX, and state all hold; EX continues to be evaluated each cycle.
- Reset mid-operation: immediate return to the reset values above; any pending redirect is discarded.

Optional Feature:
- Macro: FETCH_BRANCH_STATS_EN.
- Defined:
  - Adds outputs stat_branches (16b) and stat_mispredicts (16b).
  - Both reset to 0 and saturate at 16'hFFFF.
  - stat_branches increments on each valid EX branch, counted once per instruction (not during stall cycles).
  - stat_mispredicts increments on each mispredict.
- Undefined: ports and counters are absent; core behaviour is identical.

Test Plan:
- Reset with RESET_PC=16'h0010, rst released -> cycle 1: fetch_valid=0, fetch_pc=16'h0010; then 0011, 0012, 0013 with fetch_valid=1.
- btb_prediction=1, btb_target=16'h0040 at fetch_pc=16'h0012 -> next fetch_pc=16'h0040; two cycles later, with ex_branch=1, ex_taken=1, ex_target=16'h0040 -> mispredict=0, flush=0.
- Predicted not-taken at 16'h0020, then EX resolves ex_taken=1, ex_target=16'h0080 -> mispredict=flush=1 that cycle; next fetch_pc=16'h0080; state REDIRECT; both shadow entries invalid.
- Predicted taken to 16'h0050 at pc 16'h0030, EX resolves ex_taken=0 while stall=1 -> flush=1; next fetch_pc=16'h0031 despite stall.
- stall=1 for 3 cycles at fetch_pc=16'h0100 -> fetch_pc holds 16'h0100, no shadow advance; resumes at 16'h0101; fetch_pc=16'hFFFF sequential -> 16'h0000.
- With FETCH_BRANCH_STATS_EN: 3 branches, 1 mispredicted -> stat_branches=3, stat_mispredicts=1; asserting rst mid-run -> both counters read 0.

Source files
------------

// File: rtl/fetch_pc_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_ctrl_if
//   Bundles the fetch-stage PC controller's bus signals: hazard stall from
//   decode, BTB same-cycle lookup result, EX-stage branch resolution, and the
//   controller's fetch/flush outputs.
//
//   Modports:
//     master : the PC controller (drives fetch_pc, fetch_valid, pred_taken,
//              flush, mispredict and, with FETCH_BRANCH_STATS_EN, the stats)
//     slave  : the surrounding pipeline / environment
//
//   Optional: FETCH_BRANCH_STATS_EN adds stat_branches / stat_mispredicts.
// -----------------------------------------------------------------------------
interface fetch_pc_ctrl_if #(
    parameter int PC_W = 16
);
    logic            stall;
    logic            btb_prediction;
    logic [PC_W-1:0] btb_target;
    logic            ex_branch;
    logic            ex_taken;
    logic [PC_W-1:0] ex_target;
    logic [PC_W-1:0] fetch_pc;
    logic            fetch_valid;
    logic            pred_taken;
    logic            flush;
    logic            mispredict;
`ifdef FETCH_BRANCH_STATS_EN
    logic [15:0]     stat_branches;
    logic [15:0]     stat_mispredicts;

    modport master (
        input  stall, btb_prediction, btb_target, ex_branch, ex_taken, ex_target,
        output fetch_pc, fetch_valid, pred_taken, flush, mispredict,
        output stat_branches, stat_mispredicts
    );
    modport slave (
        output stall, btb_prediction, btb_target, ex_branch, ex_taken, ex_target,
        input  fetch_pc, fetch_valid, pred_taken, flush, mispredict,
        input  stat_branches, stat_mispredicts
    );
`else
    modport master (
        input  stall, btb_prediction, btb_target, ex_branch, ex_taken, ex_target,
        output fetch_pc, fetch_valid, pred_taken, flush, mispredict
    );
    modport slave (
        output stall, btb_prediction, btb_target, ex_branch, ex_taken, ex_target,
        input  fetch_pc, fetch_valid, pred_taken, flush, mispredict
    );
`endif
endinterface

// File: rtl/fetch_pc_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_pc_ctrl
//   Fetch-stage next-PC generator sitting directly upstream of the BTB. Owns
//   the architectural fetch PC, follows BTB predictions, shadows each fetched
//   instruction's prediction through DEC and EX, and on an EX-stage mispredict
//   redirects the PC and flushes the younger IF/DEC instructions.
//
//   Ports:
//     clk  : system clock, all state on posedge
//     rst  : asynchronous active-low reset (rst=0 resets)
//     bus  : fetch_pc_ctrl_if.master
//            in : stall, btb_prediction, btb_target,
//                 ex_branch, ex_taken, ex_target
//            out: fetch_pc, fetch_valid, pred_taken, flush, mispredict
//                 (+ stat_branches, stat_mispredicts with the option below)
//
//   Optional: define FETCH_BRANCH_STATS_EN to add saturating 16-bit counters
//   of resolved EX branches and of mispredicts.
// -----------------------------------------------------------------------------
module fetch_pc_ctrl #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    fetch_pc_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    // Sequential successor; wraps modulo 2^PC_W.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_ONE;
    endfunction

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;

    logic            fetch_valid;
    logic            pred;
    logic            mispredict;
    logic            advance;
    logic            target_miss;
    logic [PC_W-1:0] redirect_pc;

    // Shadow pipe: _p1 = DEC, _p2 = EX
    logic            vld_p1, vld_p2;
    logic            pred_p1, pred_p2;
    logic [PC_W-1:0] tgt_p1, tgt_p2;
    logic [PC_W-1:0] seq_p1, seq_p2;

    // ---------------- IF (p0): next-PC selection and EX compare -------------
    always_comb begin
        fetch_valid = (state_q != BOOT);
        // BOOT is a bubble, so any BTB hit for it is meaningless.
        pred        = fetch_valid & bus.btb_prediction;

        // Both taken but the BTB pointed somewhere else.
        target_miss = bus.ex_taken & pred_p2 & (bus.ex_target != tgt_p2);
        mispredict  = vld_p2 & bus.ex_branch &
                      ((bus.ex_taken != pred_p2) | target_miss);
        advance     = ~mispredict & ~bus.stall;
        redirect_pc = bus.ex_taken ? bus.ex_target : seq_p2;

        state_d = state_q;
        pc_d    = pc_q;
        if (mispredict) begin
            // Mispredict wins over stall: the stalled younger work is squashed.
            state_d = REDIRECT;
            pc_d    = redirect_pc;
        end else if (!bus.stall) begin
            state_d = RUN;
            if (fetch_valid && bus.btb_prediction) begin
                pc_d = bus.btb_target;
            end else begin
                pc_d = pc_inc(pc_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // ---------------- IF -> DEC (p1) -> EX (p2) shadow pipe -----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (mispredict) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (!bus.stall) begin
            vld_p1 <= fetch_valid;
            vld_p2 <= vld_p1;
        end
    end

    // Payload is only ever consumed qualified by vld_pN, so it needs no reset.
    always_ff @(posedge clk) begin
        if (advance) begin
            pred_p1 <= pred;
            tgt_p1  <= bus.btb_target;
            seq_p1  <= pc_inc(pc_q);
            pred_p2 <= pred_p1;
            tgt_p2  <= tgt_p1;
            seq_p2  <= seq_p1;
        end
    end

    assign bus.fetch_pc    = pc_q;
    assign bus.fetch_valid = fetch_valid;
    assign bus.pred_taken  = pred;
    assign bus.flush       = mispredict;
    assign bus.mispredict  = mispredict;

`ifdef FETCH_BRANCH_STATS_EN
    // ---------------- EX (p2): branch statistics ----------------------------
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] stat_br_q, stat_mp_q;
    logic        count_branch;

    // A stalled branch sits in EX for several cycles; count it only on the
    // cycle it leaves EX (normal advance, or squashed by its own mispredict).
    assign count_branch = vld_p2 & bus.ex_branch & (~bus.stall | mispredict);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_br_q <= 16'd0;
            stat_mp_q <= 16'd0;
        end else begin
            if (count_branch) begin
                stat_br_q <= sat_inc(stat_br_q);
            end
            if (mispredict) begin
                stat_mp_q <= sat_inc(stat_mp_q);
            end
        end
    end

    assign bus.stat_branches    = stat_br_q;
    assign bus.stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_ctrl
//   Self-checking bench for fetch_pc_ctrl (RESET_PC = 16'h0010). A directed
//   vector table, a few hand sequences and a randomized run are all compared
//   against a queue-based reference model of in-flight fetches.
// -----------------------------------------------------------------------------
module tb_fetch_pc_ctrl;

    localparam logic [15:0] RST_PC = 16'h0010;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fetch_pc_ctrl_if #(.PC_W(16)) bus ();

    fetch_pc_ctrl #(.PC_W(16), .RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          v;
        bit          p;
        logic [15:0] t;
        logic [15:0] n;
    } ent_t;

    ent_t        pipe[$];   // pipe[0] = DEC, pipe[1] = EX
    logic [15:0] m_pc;
    bit          m_live;    // has the first post-reset bubble been spent
    int unsigned m_br, m_mp;

    function automatic void model_reset();
        m_pc   = RST_PC;
        m_live = 0;
        m_br   = 0;
        m_mp   = 0;
        pipe.delete();
        pipe.push_back('{v:0, p:0, t:16'h0, n:16'h0});
        pipe.push_back('{v:0, p:0, t:16'h0, n:16'h0});
    endfunction

    function automatic bit model_mis();
        ent_t e = pipe[1];
        return e.v && bus.ex_branch &&
               ((bus.ex_taken != e.p) ||
                (bus.ex_taken && e.p && bus.ex_target != e.t));
    endfunction

    task automatic model_check(input int idx);
        bit mis = model_mis();
        chk("m_pc",    idx, bus.fetch_pc,    m_pc);
        chk("m_valid", idx, bus.fetch_valid, m_live);
        chk("m_pred",  idx, bus.pred_taken,  m_live & bus.btb_prediction);
        chk("m_flush", idx, bus.flush,       mis);
        chk("m_mis",   idx, bus.mispredict,  mis);
`ifdef FETCH_BRANCH_STATS_EN
        chk("m_sbr",   idx, bus.stat_branches,    m_br);
        chk("m_smp",   idx, bus.stat_mispredicts, m_mp);
`endif
    endtask

    function automatic void model_update();
        bit   mis = model_mis();
        ent_t e   = pipe[1];
        if (e.v && bus.ex_branch && (!bus.stall || mis) && m_br != 65535) m_br++;
        if (mis && m_mp != 65535) m_mp++;
        if (mis) begin
            m_pc = bus.ex_taken ? bus.ex_target : e.n;
            pipe.delete();
            pipe.push_back('{v:0, p:0, t:16'h0, n:16'h0});
            pipe.push_back('{v:0, p:0, t:16'h0, n:16'h0});
            m_live = 1;
        end else if (!bus.stall) begin
            pipe.push_front('{v:m_live, p:(m_live && bus.btb_prediction),
                              t:bus.btb_target, n:m_pc + 16'd1});
            void'(pipe.pop_back());
            m_pc   = (m_live && bus.btb_prediction) ? bus.btb_target : m_pc + 16'd1;
            m_live = 1;
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    logic [15:0] s_pc;
    logic        s_valid, s_pred, s_flush, s_mis;
    int          step_no = 0;

    task automatic step(input logic st, input logic bp, input logic [15:0] bt,
                        input logic exb, input logic ext, input logic [15:0] extgt);
        bus.stall          = st;
        bus.btb_prediction = bp;
        bus.btb_target     = bt;
        bus.ex_branch      = exb;
        bus.ex_taken       = ext;
        bus.ex_target      = extgt;
        @(negedge clk);
        s_pc    = bus.fetch_pc;
        s_valid = bus.fetch_valid;
        s_pred  = bus.pred_taken;
        s_flush = bus.flush;
        s_mis   = bus.mispredict;
        model_check(step_no);
        model_update();
        step_no++;
        @(posedge clk);
        #1;
    endtask

    // Called #1 after a posedge; leaves rst released #1 after the next posedge.
    task automatic do_reset(input int idx);
        rst                = 1'b0;
        bus.stall          = 1'b0;
        bus.btb_prediction = 1'b1;
        bus.btb_target     = 16'h5555;
        bus.ex_branch      = 1'b1;
        bus.ex_taken       = 1'b1;
        bus.ex_target      = 16'hAAAA;
        #2;
        chk("rst_pc",    idx, bus.fetch_pc,    RST_PC);
        chk("rst_valid", idx, bus.fetch_valid, 1'b0);
        chk("rst_pred",  idx, bus.pred_taken,  1'b0);
        chk("rst_flush", idx, bus.flush,       1'b0);
        chk("rst_mis",   idx, bus.mispredict,  1'b0);
`ifdef FETCH_BRANCH_STATS_EN
        chk("rst_sbr",   idx, bus.stat_branches,    16'd0);
        chk("rst_smp",   idx, bus.stat_mispredicts, 16'd0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        st;
        logic        bp;
        logic [15:0] bt;
        logic        exb;
        logic        ext;
        logic [15:0] extgt;
        logic [15:0] e_pc;
        logic        e_valid;
        logic        e_pred;
        logic        e_flush;
    } vec_t;

    vec_t tbl[22];

    initial begin
        //          st bp bt        exb ext extgt      pc       v  p  fl
        tbl[0]  = '{0, 1, 16'h7777, 0, 0, 16'h0000, 16'h0010, 0, 0, 0}; // BOOT ignores BTB
        tbl[1]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0011, 1, 0, 0};
        tbl[2]  = '{0, 1, 16'h0040, 0, 0, 16'h0000, 16'h0012, 1, 1, 0};
        tbl[3]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0040, 1, 0, 0};
        tbl[4]  = '{0, 0, 16'h0000, 1, 1, 16'h0040, 16'h0041, 1, 0, 0}; // correct taken
        tbl[5]  = '{0, 1, 16'h0020, 0, 0, 16'h0000, 16'h0042, 1, 1, 0};
        tbl[6]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0020, 1, 0, 0};
        tbl[7]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0021, 1, 0, 0};
        tbl[8]  = '{0, 0, 16'h0000, 1, 1, 16'h0080, 16'h0022, 1, 0, 1}; // NT predicted, taken
        tbl[9]  = '{0, 0, 16'h0000, 1, 1, 16'h1234, 16'h0080, 1, 0, 0}; // EX bubble
        tbl[10] = '{0, 1, 16'h0030, 1, 0, 16'h0000, 16'h0081, 1, 1, 0}; // EX bubble
        tbl[11] = '{0, 1, 16'h0050, 0, 0, 16'h0000, 16'h0030, 1, 1, 0};
        tbl[12] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0050, 1, 0, 0};
        tbl[13] = '{1, 0, 16'h0000, 1, 0, 16'h0000, 16'h0051, 1, 0, 1}; // mispredict under stall
        tbl[14] = '{0, 1, 16'h0100, 0, 0, 16'h0000, 16'h0031, 1, 1, 0};
        tbl[15] = '{1, 1, 16'h0200, 0, 0, 16'h0000, 16'h0100, 1, 1, 0};
        tbl[16] = '{1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0100, 1, 0, 0};
        tbl[17] = '{1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0100, 1, 0, 0};
        tbl[18] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0100, 1, 0, 0};
        tbl[19] = '{0, 1, 16'hFFFF, 0, 0, 16'h0000, 16'h0101, 1, 1, 0}; // non-branch, pred'd taken
        tbl[20] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 16'hFFFF, 1, 0, 0};
        tbl[21] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0}; // wrap

        #1;
        do_reset(0);

        foreach (tbl[i]) begin
            step(tbl[i].st, tbl[i].bp, tbl[i].bt, tbl[i].exb, tbl[i].ext, tbl[i].extgt);
            chk("tbl_pc",    i, s_pc,    tbl[i].e_pc);
            chk("tbl_valid", i, s_valid, tbl[i].e_valid);
            chk("tbl_pred",  i, s_pred,  tbl[i].e_pred);
            chk("tbl_flush", i, s_flush, tbl[i].e_flush);
            chk("tbl_mis",   i, s_mis,   tbl[i].e_flush);
        end

`ifdef FETCH_BRANCH_STATS_EN
        // Branches resolved in rows 4, 8, 13; rows 8 and 13 mispredicted.
        chk("tbl_sbr", 0, bus.stat_branches,    16'd3);
        chk("tbl_smp", 0, bus.stat_mispredicts, 16'd2);
`endif

        // Taken/taken but wrong target: fetch 0x0001 predicted to 0x0300.
        step(0, 1, 16'h0300, 0, 0, 16'h0000);
        step(0, 0, 16'h0000, 0, 0, 16'h0000);
        step(0, 0, 16'h0000, 1, 1, 16'h0301);
        chk("tgt_flush", 0, s_flush, 1'b1);
        step(0, 0, 16'h0000, 0, 0, 16'h0000);
        chk("tgt_pc", 0, s_pc, 16'h0301);

        // Reset in the middle of a redirect: pending correction is discarded.
        step(0, 1, 16'h0400, 0, 0, 16'h0000);
        step(0, 0, 16'h0000, 0, 0, 16'h0000);
        bus.ex_branch = 1'b1;
        bus.ex_taken  = 1'b0;
        #1;
        chk("mid_flush", 0, bus.flush, 1'b1);
        do_reset(1);
        step(0, 0, 16'h0000, 0, 0, 16'h0000);
        chk("mid_pc0", 0, s_pc, RST_PC);
        chk("mid_v0",  0, s_valid, 1'b0);
        step(0, 0, 16'h0000, 0, 0, 16'h0000);
        chk("mid_pc1", 0, s_pc, RST_PC + 16'd1);

        // Randomized run against the model.
        for (int k = 0; k < 600; k++) begin
            logic        st, bp, exb, ext;
            logic [15:0] bt, extgt;
            st  = ($urandom_range(0, 3) == 0);
            bp  = $urandom_range(0, 1);
            case ($urandom_range(0, 2))
                0:       bt = 16'hFFFF;
                1:       bt = 16'h0040 + 16'($urandom_range(0, 3));
                default: bt = 16'($urandom);
            endcase
            exb   = ($urandom_range(0, 2) != 0);
            ext   = $urandom_range(0, 1);
            extgt = $urandom_range(0, 1) ? pipe[1].t : 16'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                do_reset(k + 2);
            end
            step(st, bp, bt, exb, ext, extgt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
